// File: rtl/attn_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// attn_seq_ctrl_if
// Handshake/status bundle between the attention-core sequencer and the core.
//
// Signals (direction seen from the sequencer, modport master):
//   start      in   begin a run (sampled only while idle)
//   q_full     in   Q SRAM full
//   k_full     in   K SRAM full
//   ld_done    in   all MAC columns finished loading
//   exec_done  in   execution complete
//   out_wr     in   OFIFO holds valid output
//   p_full     in   PMEM full
//   inst       out  instruction word, 12+2*ADDR_W bits
//   done       out  sequencer idle
//   busy       out  ~done
//   op_valid   out  PMEM readout data valid
//   err        out  sticky watchdog error
//   state_dbg  out  current FSM state encoding, for debug/checkers
//
// Flag semantics: every input flag is a level, sampled on the rising clock
// edge, and only honoured in the state that waits on it; there is no
// ready/acknowledge path back to the core.
// -----------------------------------------------------------------------------
interface attn_seq_ctrl_if #(
   parameter int ADDR_W = 4
);
   localparam int INST_W = 12 + 2 * ADDR_W;

   logic              start;
   logic              q_full;
   logic              k_full;
   logic              ld_done;
   logic              exec_done;
   logic              out_wr;
   logic              p_full;
   logic [INST_W-1:0] inst;
   logic              done;
   logic              busy;
   logic              op_valid;
   logic              err;
   logic [3:0]        state_dbg;

   modport master (
      input  start, q_full, k_full, ld_done, exec_done, out_wr, p_full,
      output inst, done, busy, op_valid, err, state_dbg
   );

   modport slave (
      output start, q_full, k_full, ld_done, exec_done, out_wr, p_full,
      input  inst, done, busy, op_valid, err, state_dbg
   );
endinterface

// File: rtl/attn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// attn_seq_ctrl
// Top-level sequencer for one attention core: Q write, K write, K load,
// execute, OFIFO drain to PMEM, per-row SFP normalisation, output readout.
// One registered instruction word is issued per clock.
//
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset (also aborts a run in progress)
//   bus    attn_seq_ctrl_if.master (start/flags in; inst/done/busy/op_valid/
//          err/state_dbg out)
//
// Instruction word: [0] pmem_wr [1] pmem_rd [2] kmem_wr [3] kmem_rd
//   [4] qmem_wr [5] qmem_rd [6] load [7] execute [8+:ADDR_W] pmem_add
//   [8+ADDR_W+:ADDR_W] qkmem_add; top four bits MSB first: sfp_wr, sfp_acc,
//   sfp_div, ofifo_rd.
//
// Optional feature: define ATTN_SEQ_CTRL_TIMEOUT_EN to enable a watchdog on
// K_LOAD, EXEC and OFIFO_HOLD that aborts to IDLE and sets a sticky err after
// TIMEOUT_CYC cycles in one of those states. Undefined: err is always 0.
//
// Timing: each edge decides the word for the current state/counter and the
// next state; the word appears on inst after that edge. On an edge where a
// terminating flag is seen the word is idle (K_LOAD keeps load=1), so the
// flag's effect is visible on the following cycle.
// -----------------------------------------------------------------------------
module attn_seq_ctrl #(
   parameter int ADDR_W        = 4,
   parameter int Q_ROWS        = 16,
   parameter int K_ROWS        = 8,
   parameter int P_ROWS        = 8,
   parameter int LOAD_HOLD_CYC = 4,
   parameter int SFP_GAP       = 2,
   parameter int TIMEOUT_CYC   = 1024
) (
   input  logic            clk,
   input  logic            reset,
   attn_seq_ctrl_if.master bus
);
   localparam int INST_W = 12 + 2 * ADDR_W;
   // Counter must reach K_ROWS (saturation marker) and LOAD_HOLD_CYC-1.
   localparam int CNT_W  = (ADDR_W + 1 > $clog2(LOAD_HOLD_CYC) + 1) ?
                           ADDR_W + 1 : $clog2(LOAD_HOLD_CYC) + 1;
   localparam int PH_W   = $clog2(SFP_GAP + 5);

   localparam int B_PWR = 0, B_PRD = 1, B_KWR = 2, B_KRD = 3;
   localparam int B_QWR = 4, B_QRD = 5, B_LOAD = 6, B_EXEC = 7;
   localparam int P_LSB = 8, QK_LSB = 8 + ADDR_W;
   localparam int B_OFRD = INST_W - 4, B_DIV = INST_W - 3;
   localparam int B_ACC  = INST_W - 2, B_SWR = INST_W - 1;

   typedef enum logic [3:0] {
      S_IDLE, S_Q_WRITE, S_K_WRITE, S_K_LOAD, S_LOAD_HOLD,
      S_EXEC, S_OFIFO_HOLD, S_PMEM_WRITE, S_SFP, S_GEN_OUTPUT
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PH_W-1:0]     ph_q, ph_d;
   logic [INST_W-1:0]   inst_q, inst_d;
   logic                gen_rd_q, gen_rd_d;
   logic                op_valid_q, done_q, busy_q, err_q;
   logic                tmo_hit;
   logic [ADDR_W-1:0]   row_add, held_add;

   assign row_add  = cnt_q[ADDR_W-1:0];
   // Last issued K read address; cnt==K_ROWS wraps to K_ROWS-1 here.
   assign held_add = cnt_q[ADDR_W-1:0] - ADDR_W'(cnt_q != '0);

`ifdef ATTN_SEQ_CTRL_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q;
   logic             tmo_state;

   assign tmo_state = (state_q == S_K_LOAD) || (state_q == S_EXEC) ||
                      (state_q == S_OFIFO_HOLD);
   assign tmo_hit   = tmo_state && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset || (state_d != state_q) || !tmo_state) tmo_q <= '0;
      else                                               tmo_q <= tmo_q + 1'b1;
   end
`else
   assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ph_d     = ph_q;
      inst_d   = '0;
      gen_rd_d = 1'b0;
      unique case (state_q)
         S_IDLE: if (bus.start) state_d = S_Q_WRITE;
         S_Q_WRITE: begin
            if (bus.q_full) state_d = S_K_WRITE;
            else begin
               inst_d[B_QWR] = 1'b1;
               inst_d[QK_LSB +: ADDR_W] = row_add;
               if (cnt_q == CNT_W'(Q_ROWS - 1)) state_d = S_K_WRITE;
               else                             cnt_d   = cnt_q + 1'b1;
            end
         end
         S_K_WRITE: begin
            if (bus.k_full) state_d = S_K_LOAD;
            else begin
               inst_d[B_KWR] = 1'b1;
               inst_d[QK_LSB +: ADDR_W] = row_add;
               if (cnt_q == CNT_W'(K_ROWS - 1)) state_d = S_K_LOAD;
               else                             cnt_d   = cnt_q + 1'b1;
            end
         end
         S_K_LOAD: begin
            inst_d[B_LOAD] = 1'b1;
            inst_d[QK_LSB +: ADDR_W] = held_add;
            if (bus.ld_done) state_d = S_LOAD_HOLD;
            else if (cnt_q < CNT_W'(K_ROWS)) begin
               inst_d[B_KRD] = 1'b1;
               inst_d[QK_LSB +: ADDR_W] = row_add;
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LOAD_HOLD: begin
            if (cnt_q == CNT_W'(LOAD_HOLD_CYC - 1)) state_d = S_EXEC;
            else                                    cnt_d   = cnt_q + 1'b1;
         end
         S_EXEC: begin
            if (bus.exec_done) state_d = S_OFIFO_HOLD;
            else begin
               inst_d[B_EXEC] = 1'b1;
               inst_d[B_QRD]  = 1'b1;
               inst_d[QK_LSB +: ADDR_W] = row_add;   // wraps with the counter
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_OFIFO_HOLD: if (bus.out_wr) state_d = S_PMEM_WRITE;
         S_PMEM_WRITE: begin
            if (bus.p_full) state_d = S_SFP;
            else begin
               inst_d[B_OFRD] = 1'b1;
               inst_d[B_PWR]  = 1'b1;
               inst_d[P_LSB +: ADDR_W] = row_add;
               if (cnt_q == CNT_W'(P_ROWS - 1)) state_d = S_SFP;
               else                             cnt_d   = cnt_q + 1'b1;
            end
         end
         S_SFP: begin
            // Row r = cnt; ph walks RD, ACC, gap..., DIV, WR, HOLD.
            ph_d = ph_q + 1'b1;
            if (ph_q == '0) begin
               inst_d[B_PRD] = 1'b1;
               inst_d[P_LSB +: ADDR_W] = row_add;
            end else if (ph_q == PH_W'(1)) begin
               inst_d[B_ACC] = 1'b1;
            end else if (ph_q == PH_W'(SFP_GAP + 2)) begin
               inst_d[B_DIV] = 1'b1;
            end else if (ph_q == PH_W'(SFP_GAP + 3)) begin
               inst_d[B_PWR] = 1'b1;
               inst_d[B_SWR] = 1'b1;
               inst_d[P_LSB +: ADDR_W] = row_add;
            end else if (ph_q == PH_W'(SFP_GAP + 4)) begin
               inst_d[B_PWR] = 1'b1;
               inst_d[P_LSB +: ADDR_W] = row_add;
               ph_d = '0;
               if (cnt_q == CNT_W'(P_ROWS - 1)) state_d = S_GEN_OUTPUT;
               else                             cnt_d   = cnt_q + 1'b1;
            end
         end
         S_GEN_OUTPUT: begin
            inst_d[B_PRD] = 1'b1;
            inst_d[P_LSB +: ADDR_W] = row_add;
            gen_rd_d = 1'b1;
            if (cnt_q == CNT_W'(P_ROWS - 1)) state_d = S_IDLE;
            else                             cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (tmo_hit) begin
         state_d  = S_IDLE;
         inst_d   = '0;
         gen_rd_d = 1'b0;
      end
      if (state_d != state_q) begin
         cnt_d = '0;
         ph_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ph_q       <= '0;
         inst_q     <= '0;
         gen_rd_q   <= 1'b0;
         op_valid_q <= 1'b0;
         done_q     <= 1'b1;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ph_q       <= ph_d;
         inst_q     <= inst_d;
         gen_rd_q   <= gen_rd_d;
         op_valid_q <= gen_rd_q;   // one-cycle PMEM read latency
         done_q     <= (state_d == S_IDLE);
         busy_q     <= (state_d != S_IDLE);
         err_q      <= err_q | tmo_hit;
      end
   end

   assign bus.inst      = inst_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.op_valid  = op_valid_q;
   assign bus.err       = err_q;
   assign bus.state_dbg = state_q;
endmodule

// File: doc/attn_seq_ctrl.md
Name: attn_seq_ctrl

Overview:
- Parametrised top-level sequencer for one attention core.
- Drives the full flow: Q write, K write, K load into the MAC array, execute, OFIFO drain to PMEM, per-row SFP normalisation, output readout.
- Issues one registered instruction word per cycle to the core datapath and memories.
- Generalises the fixed-depth controller: independent row counts per phase, parametrised address width, configurable hold/gap timing, explicit busy/op_valid framing, and per-phase counter-or-flag termination.

Parameters:
ADDR_W, 4, width of qkmem_add and pmem_add fields
Q_ROWS, 16, max Q rows written (≤ 2^ADDR_W)
K_ROWS, 8, max K rows written and loaded (≤ 2^ADDR_W)
P_ROWS, 8, PMEM rows written, normalised and read out (≤ 2^ADDR_W)
LOAD_HOLD_CYC, 4, idle cycles between load end and execute start (≥ 1)
SFP_GAP, 2, idle cycles between sfp_acc and sfp_div per row (≥ 0)
TIMEOUT_CYC, 1024, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin a run; sampled in IDLE only
q_full  in  1  Q SRAM full
k_full  in  1  K SRAM full
ld_done  in  1  all MAC columns have finished loading
exec_done  in  1  execution complete
out_wr  in  1  OFIFO has valid output
p_full  in  1  PMEM full
inst  out  12+2*ADDR_W  instruction word
- inst[0] pmem_wr; [1] pmem_rd; [2] kmem_wr; [3] kmem_rd; [4] qmem_wr; [5] qmem_rd; [6] load; [7] execute
- [8 +: ADDR_W] pmem_add; [8+ADDR_W +: ADDR_W] qkmem_add
- top four bits, MSB first: sfp_wr, sfp_acc, sfp_div, ofifo_rd
done  out  1  high in IDLE
busy  out  1  ~done
op_valid  out  1  PMEM readout data valid
err  out  1  sticky watchdog error

Behaviour:
- Reset (synchronous, active-high; applies mid-run):
  - state=IDLE, all counters=0, inst=0, done=1, busy=0, op_valid=0, err=0.
- Registering: all outputs registered; a state decision made at edge N takes effect at edge N+1. cnt is a single shared row counter, zeroed on every state change.
- IDLE: inst=0. start=1 → Q_WRITE. start is ignored in all other states.
- Q_WRITE: qmem_wr=1, qkmem_add=cnt, cnt++ each cycle.
  - Exit when q_full=1, or when the word at cnt=Q_ROWS-1 is issued, whichever comes first; if both occur in the same cycle, exit once.
  - On exit: qmem_wr drops next cycle; → K_WRITE.
- K_WRITE: same as Q_WRITE using kmem_wr, k_full and K_ROWS. → K_LOAD.
- K_LOAD: load=1 throughout.
  - kmem_rd=1 with qkmem_add=cnt for cnt=0..K_ROWS-1, then kmem_rd=0 with address held.
  - ld_done=1 → LOAD_HOLD. ld_done arriving before all K_ROWS reads are issued still exits; remaining reads are dropped.
- LOAD_HOLD: inst=0 for exactly LOAD_HOLD_CYC cycles → EXEC.
- EXEC: execute=1, qmem_rd=1, qkmem_add=cnt; the address wraps modulo 2^ADDR_W. exec_done=1 → OFIFO_HOLD.
- OFIFO_HOLD: inst=0 until out_wr=1 → PMEM_WRITE.
- PMEM_WRITE: ofifo_rd=1, pmem_wr=1, pmem_add=cnt. Exit on p_full, or after the write at cnt=P_ROWS-1 → SFP with row r=0.
- SFP: per-row phase sequence:
  - RD (pmem_rd, pmem_add=r)
  - ACC (sfp_acc)
  - SFP_GAP idle cycles
  - DIV (sfp_div)
  - WR (pmem_wr, sfp_wr, pmem_add=r)
  - HOLD (pmem_wr, pmem_add=r)
  - Each row takes 5+SFP_GAP cycles. Only the listed bits are high in each phase. After r=P_ROWS-1 → GEN_OUTPUT.
- GEN_OUTPUT: pmem_rd=1, pmem_add=cnt for cnt=0..P_ROWS-1, then → IDLE with inst=0.
  - op_valid = pmem_rd delayed one cycle (1-cycle PMEM read latency), giving exactly P_ROWS op_valid pulses.
- Flags asserted while in a state not listed as sampling them are ignored.

Optional Feature:
- Macro ATTN_SEQ_CTRL_TIMEOUT_EN.
- When defined: a cycle counter runs in K_LOAD, EXEC and OFIFO_HOLD and clears on entry to each.
  - Reaching TIMEOUT_CYC forces IDLE with inst=0 and sets err=1.
  - err clears only on reset; start is still accepted after an error.
- When undefined: err is tied to 0 and wait states wait indefinitely.

Test Plan:
1. Reset, pulse start; q_full never asserts → 16 qmem_wr cycles with qkmem_add 0..15, then kmem_wr with addresses 0..7, then the K_LOAD window opens.
2. Assert q_full after 5 Q writes → qmem_wr high for exactly those 5 cycles (addresses 0..4); the K_WRITE phase then begins with address 0.
3. ld_done 10 cycles into K_LOAD → kmem_rd high for exactly 8 cycles; inst=0 for exactly 4 cycles; then execute=1 and qmem_rd=1.
4. Full run with P_ROWS=8, SFP_GAP=2 → SFP phase lasts 56 cycles; sfp_wr pulses at pmem_add 0..7; 8 op_valid pulses; done=1 afterwards.
5. Reset asserted mid-EXEC → next cycle inst=0 and done=1; a new start runs normally from Q_WRITE.
6. With ATTN_SEQ_CTRL_TIMEOUT_EN and TIMEOUT_CYC=32, exec_done held low → IDLE after 32 EXEC cycles, err=1 until reset.
